// File: rtl/wb_bus_arbiter_pkg.sv
// rtl/wb_bus_arbiter_pkg.sv - shared types and widths for the WISHBONE round-robin arbiter
package wb_bus_arbiter_pkg;

    localparam int WB_N_MASTERS = 4;
    localparam int HOLD_W       = 16;
    localparam int GAP_W        = 4;

    typedef enum logic [1:0] {
        ARB_ST_IDLE  = 2'd0,
        ARB_ST_GRANT = 2'd1,
        ARB_ST_GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - round-robin pick: rotate by ptr, find first set, rotate back
module rr_priority_pick #(
    parameter int N_MASTERS = 4,
    parameter int ID_W      = 2
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [ID_W-1:0]      ptr,
    output logic                 found,
    output logic [ID_W-1:0]      winner
);

    logic [2*N_MASTERS-1:0] dbl;
    logic [N_MASTERS-1:0]   rot;
    logic [ID_W-1:0]        ofs;
    logic [ID_W:0]          sum;

    always_comb begin
        // Bit 0 of rot is the request at ptr, so the lowest set bit is the next in turn.
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_MASTERS-1:0];
        found = |rot;
        ofs   = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                ofs = ID_W'(i);
            end
        end
        sum = {1'b0, ofs} + {1'b0, ptr};
        if (sum >= (ID_W+1)'(N_MASTERS)) begin
            winner = ID_W'(sum - (ID_W+1)'(N_MASTERS));
        end else begin
            winner = sum[ID_W-1:0];
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin WISHBONE bus arbiter with release gap and grant watchdog
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS     = WB_N_MASTERS,
    parameter int ID_W          = 2,
    parameter int GNT_GAP       = 1,
    parameter int GRANT_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] cyc_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [ID_W-1:0]      gnt_id_o,
    output logic                 bus_busy_o,
    output logic [N_MASTERS-1:0] timeout_o
);

    localparam logic [HOLD_W-1:0]    TO_LAST  = HOLD_W'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((GNT_GAP > 0) ? GNT_GAP - 1 : 0);
    localparam logic [N_MASTERS-1:0] ONE      = N_MASTERS'(1);

    arb_state_t           state;
    logic [ID_W-1:0]      ptr;
    logic [N_MASTERS-1:0] blocked;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [GAP_W-1:0]     gap_cnt;

    logic [N_MASTERS-1:0] req;
    logic                 found;
    logic [ID_W-1:0]      winner;
    logic                 holder_req;
    logic                 timed_out;
    logic                 release_now;
    logic                 take;
    logic                 revoke;

    // The current holder is masked out so a watchdog revoke can hand over in the same edge.
    assign req = cyc_i & ~blocked & ~gnt_o;

    rr_priority_pick #(
        .N_MASTERS(N_MASTERS),
        .ID_W     (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .winner(winner)
    );

    assign holder_req  = cyc_i[gnt_id_o];
    assign timed_out   = (GRANT_TIMEOUT > 0) && (hold_cnt == TO_LAST);
    assign release_now = (state == ARB_ST_GRANT) && (!holder_req || timed_out);
    assign revoke      = release_now && holder_req;
    assign take        = found && ((state == ARB_ST_IDLE) || (release_now && (GNT_GAP == 0)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_ST_IDLE;
            ptr        <= '0;
            blocked    <= '0;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            gnt_o      <= '0;
            gnt_id_o   <= '0;
            bus_busy_o <= 1'b0;
            timeout_o  <= '0;
        end else begin
            blocked   <= (blocked & cyc_i) | (revoke ? (ONE << gnt_id_o) : '0);
            timeout_o <= revoke ? (ONE << gnt_id_o) : '0;

            if (take) begin
                gnt_o      <= ONE << winner;
                gnt_id_o   <= winner;
                bus_busy_o <= 1'b1;
                ptr        <= (winner == ID_W'(N_MASTERS - 1)) ? '0 : winner + 1'b1;
                hold_cnt   <= '0;
                state      <= ARB_ST_GRANT;
            end else if (release_now) begin
                gnt_o      <= '0;
                bus_busy_o <= 1'b0;
                gap_cnt    <= '0;
                state      <= (GNT_GAP > 0) ? ARB_ST_GAP : ARB_ST_IDLE;
            end else if (state == ARB_ST_GAP) begin
                if (gap_cnt == GAP_LAST) begin
                    state <= ARB_ST_IDLE;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end else if (state == ARB_ST_GRANT) begin
                if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - randomized and directed checks of three arbiter configurations against a reference model
module tb_wb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] cyc0, cyc1, cyc2;
    logic [3:0] gnt0, gnt1, gnt2;
    logic [1:0] id0, id1, id2;
    logic       busy0, busy1, busy2;
    logic [3:0] tout0, tout1, tout2;

    int errors = 0;
    int checks = 0;

    int gap_p [3] = '{1, 0, 3};
    int to_p  [3] = '{0, 8, 5};

    // Reference model: holder index (-1 = none), edges held, blocked edges left, next in turn.
    int         m_holder [3];
    int         m_held   [3];
    int         m_wait   [3];
    int         m_pri    [3];
    logic [3:0] m_blk    [3];
    logic [3:0] m_tout   [3];

    wb_bus_arbiter #(.N_MASTERS(4), .ID_W(2), .GNT_GAP(1), .GRANT_TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .cyc_i(cyc0), .gnt_o(gnt0), .gnt_id_o(id0),
        .bus_busy_o(busy0), .timeout_o(tout0)
    );
    wb_bus_arbiter #(.N_MASTERS(4), .ID_W(2), .GNT_GAP(0), .GRANT_TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .cyc_i(cyc1), .gnt_o(gnt1), .gnt_id_o(id1),
        .bus_busy_o(busy1), .timeout_o(tout1)
    );
    wb_bus_arbiter #(.N_MASTERS(4), .ID_W(2), .GNT_GAP(3), .GRANT_TIMEOUT(5)) dut2 (
        .clk(clk), .rst(rst), .cyc_i(cyc2), .gnt_o(gnt2), .gnt_id_o(id2),
        .bus_busy_o(busy2), .timeout_o(tout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic reset_model(input int d);
        m_holder[d] = -1;
        m_held[d]   = 0;
        m_wait[d]   = 0;
        m_pri[d]    = 0;
        m_blk[d]    = 4'b0;
        m_tout[d]   = 4'b0;
    endtask

    task automatic grant_from(input int d, input logic [3:0] r);
        int w;
        w = pick(r, m_pri[d]);
        if (w >= 0) begin
            m_holder[d] = w;
            m_held[d]   = 0;
            m_pri[d]    = (w + 1) % 4;
        end
    endtask

    task automatic step_model(input int d, input logic [3:0] c);
        logic [3:0] nb;
        bit         rel;
        nb        = m_blk[d] & c;
        m_tout[d] = 4'b0;
        rel       = 1'b0;
        if (m_holder[d] >= 0) begin
            if (!c[m_holder[d]]) begin
                rel = 1'b1;
            end else if (to_p[d] > 0 && m_held[d] == to_p[d] - 1) begin
                rel = 1'b1;
                m_tout[d][m_holder[d]] = 1'b1;
                nb[m_holder[d]] = 1'b1;
            end else begin
                m_held[d]++;
            end
            if (rel) begin
                m_holder[d] = -1;
                if (gap_p[d] > 0) m_wait[d] = gap_p[d];
                else grant_from(d, c & ~nb);
            end
        end else if (m_wait[d] > 0) begin
            m_wait[d]--;
        end else begin
            grant_from(d, c & ~m_blk[d]);
        end
        m_blk[d] = nb;
    endtask

    task automatic compare_one(input int d, input logic [3:0] g, input logic [1:0] id,
                               input logic b, input logic [3:0] t);
        logic [3:0] eg;
        eg = (m_holder[d] >= 0) ? (4'(1) << m_holder[d]) : 4'b0;
        check_eq($sformatf("d%0d_gnt", d), 32'(g), 32'(eg));
        check_eq($sformatf("d%0d_busy", d), 32'(b), 32'(m_holder[d] >= 0));
        check_eq($sformatf("d%0d_tout", d), 32'(t), 32'(m_tout[d]));
        if (m_holder[d] >= 0) check_eq($sformatf("d%0d_id", d), 32'(id), 32'(m_holder[d]));
    endtask

    task automatic compare_all();
        compare_one(0, gnt0, id0, busy0, tout0);
        compare_one(1, gnt1, id1, busy1, tout1);
        compare_one(2, gnt2, id2, busy2, tout2);
    endtask

    task automatic cycle();
        @(posedge clk);
        step_model(0, cyc0);
        step_model(1, cyc1);
        step_model(2, cyc2);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_all(input logic [3:0] c);
        cyc0 = c;
        cyc1 = c;
        cyc2 = c;
    endtask

    function automatic logic [3:0] flips();
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = ($urandom_range(0, 4) == 0);
        return f;
    endfunction

    initial begin
        rst = 1'b0;
        set_all(4'b0000);
        for (int d = 0; d < 3; d++) reset_model(d);
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        check_eq("rst_id0", 32'(id0), 32'd0);
        rst = 1'b1;

        // Single request, release and gap on the GNT_GAP=1 instance.
        set_all(4'b0001);
        cycle();
        check_eq("t1_gnt", 32'(gnt0), 32'b0001);
        check_eq("t1_id", 32'(id0), 32'd0);
        set_all(4'b0000);
        cycle();
        check_eq("t1_rel", 32'(gnt0), 32'b0000);
        cycle();
        check_eq("t1_gap", 32'(gnt0), 32'b0000);

        // No preemption, then back-to-back hand-over on the GNT_GAP=0 instance.
        set_all(4'b0001);
        cycle();
        set_all(4'b0011);
        cycle();
        check_eq("t5_hold", 32'(gnt1), 32'b0001);
        set_all(4'b0010);
        cycle();
        check_eq("t5_b2b", 32'(gnt1), 32'b0010);
        check_eq("t5_gap_d0", 32'(gnt0), 32'b0000);

        // Asynchronous reset in the middle of a grant.
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) reset_model(d);
        compare_all();
        set_all(4'b1000);
        @(negedge clk);
        rst = 1'b1;
        cycle();
        check_eq("t6_gnt1", 32'(gnt1), 32'b1000);
        check_eq("t6_gnt0", 32'(gnt0), 32'b1000);

        // Watchdog revoke on the GRANT_TIMEOUT=8 instance.
        set_all(4'b0000);
        cycle();
        set_all(4'b0010);
        cycle();
        check_eq("t4_grant", 32'(gnt1), 32'b0010);
        set_all(4'b1010);
        repeat (7) cycle();
        check_eq("t4_held", 32'(gnt1), 32'b0010);
        cycle();
        check_eq("t4_tout", 32'(tout1), 32'b0010);
        check_eq("t4_next", 32'(gnt1), 32'b1000);
        cycle();
        check_eq("t4_pulse", 32'(tout1), 32'b0000);
        set_all(4'b0010);
        cycle();
        check_eq("t4_blocked", 32'(gnt1), 32'b0000);
        set_all(4'b0000);
        cycle();
        set_all(4'b0010);
        cycle();
        check_eq("t4_regrant", 32'(gnt1), 32'b0010);

        repeat (3000) begin
            cyc0 = cyc0 ^ flips();
            cyc1 = cyc1 ^ flips();
            cyc2 = cyc2 ^ flips();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
